// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - two-source register-file writeback arbiter with per-source FIFOs
// Optional key check compiled in with WB_KEY_CHECK_EN.
module reg_writeback_ctrl #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic [15:0] key_in,
  input  logic [15:0] key_access,
  input  logic        fault_clr,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_src,
  output logic        key_fault,
  output logic [7:0]  drop_count,
  output logic        locked
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, LOCKED = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [36:0]   r_alu_buf [FIFO_DEPTH];
  logic [36:0]   r_mem_buf [FIFO_DEPTH];
  logic [AW-1:0] r_alu_wp, r_alu_rp, r_mem_wp, r_mem_rp;
  logic [CW-1:0] r_alu_cnt, r_mem_cnt;
  logic          r_last_mem;
  logic          r_wr_en, r_wr_src;
  logic [4:0]    r_wr_addr;
  logic [31:0]   r_wr_data;

  logic        w_alu_push, w_mem_push, w_alu_ne, w_mem_ne;
  logic        w_pop_alu, w_pop_mem, w_issue, w_drop, w_key_match;
  logic [36:0] w_grant_entry;

  // Ready depends on current occupancy only, so a same-cycle pop never frees a slot early.
  assign alu_ready  = ~rst & (r_alu_cnt != FULL) & (r_state == RUN);
  assign mem_ready  = ~rst & (r_mem_cnt != FULL) & (r_state == RUN);
  assign w_alu_push = alu_valid & alu_ready;
  assign w_mem_push = mem_valid & mem_ready;
  assign w_alu_ne   = (r_alu_cnt != '0);
  assign w_mem_ne   = (r_mem_cnt != '0);

`ifdef WB_KEY_CHECK_EN
  assign w_key_match = (key_in == key_access);
`else
  logic w_unused_keys;
  assign w_key_match   = 1'b1;
  assign w_unused_keys = ^{key_in, key_access, fault_clr, w_drop};
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_pop_alu     = 1'b0;
    w_pop_mem     = 1'b0;
    w_issue       = 1'b0;
    w_drop        = 1'b0;
    w_grant_entry = r_alu_buf[r_alu_rp];
    if (r_state == RUN) begin
      if (w_alu_ne && (!w_mem_ne || r_last_mem)) begin
        w_pop_alu = 1'b1;
      end else if (w_mem_ne) begin
        w_pop_mem     = 1'b1;
        w_grant_entry = r_mem_buf[r_mem_rp];
      end
      if (w_pop_alu || w_pop_mem) begin
        if (!w_key_match) begin
          w_drop      = 1'b1;
          w_state_nxt = LOCKED;
        end else begin
          w_issue = (w_grant_entry[36:32] != 5'd0);
        end
      end
    end else if (w_key_match) begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_alu_push) r_alu_buf[r_alu_wp] <= {alu_rd, alu_data};
    if (w_mem_push) r_mem_buf[r_mem_wp] <= {mem_rd, mem_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_wp  <= '0;
      r_alu_rp  <= '0;
      r_alu_cnt <= '0;
      r_mem_wp  <= '0;
      r_mem_rp  <= '0;
      r_mem_cnt <= '0;
    end else begin
      if (w_alu_push) r_alu_wp <= r_alu_wp + 1'b1;
      if (w_pop_alu)  r_alu_rp <= r_alu_rp + 1'b1;
      if (w_mem_push) r_mem_wp <= r_mem_wp + 1'b1;
      if (w_pop_mem)  r_mem_rp <= r_mem_rp + 1'b1;
      case ({w_alu_push, w_pop_alu})
        2'b10:   r_alu_cnt <= r_alu_cnt + 1'b1;
        2'b01:   r_alu_cnt <= r_alu_cnt - 1'b1;
        default: r_alu_cnt <= r_alu_cnt;
      endcase
      case ({w_mem_push, w_pop_mem})
        2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
        2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
        default: r_mem_cnt <= r_mem_cnt;
      endcase
    end
  end

  // r_last_mem starts at 1 so the ALU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_mem <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 5'd0;
      r_wr_data  <= 32'd0;
      r_wr_src   <= 1'b0;
    end else begin
      r_wr_en <= w_issue;
      if (w_pop_alu || w_pop_mem) r_last_mem <= w_pop_mem;
      if (w_issue) begin
        r_wr_addr <= w_grant_entry[36:32];
        r_wr_data <= w_grant_entry[31:0];
        r_wr_src  <= w_pop_mem;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign wr_src  = r_wr_src;

`ifdef WB_KEY_CHECK_EN
  logic       r_key_fault;
  logic [7:0] r_drop_count;

  // A new mismatch outranks fault_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_fault  <= 1'b0;
      r_drop_count <= 8'd0;
    end else if (w_drop) begin
      r_key_fault <= 1'b1;
      if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end else if (fault_clr) begin
      r_key_fault <= 1'b0;
    end
  end

  assign key_fault  = r_key_fault;
  assign drop_count = r_drop_count;
  assign locked     = (r_state == LOCKED);
`else
  assign key_fault  = 1'b0;
  assign drop_count = 8'd0;
  assign locked     = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb/tb_reg_writeback_ctrl.sv - scoreboard bench for reg_writeback_ctrl
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, fault_clr = 1'b0;
  logic [4:0]  alu_rd = '0, mem_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic [15:0] key_in = 16'h0032, key_access = 16'h0032;
  logic        alu_ready, mem_ready, wr_en, wr_src, key_fault, locked;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  drop_count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  reg_writeback_ctrl #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .key_in(key_in), .key_access(key_access), .fault_clr(fault_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src),
    .key_fault(key_fault), .drop_count(drop_count), .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h src=%0d at cyc %0d", wr_addr, wr_data, wr_src, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data || wr_src !== mon_e.src ||
            (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h src=%0d cyc=%0d exp addr=%0d data=%h src=%0d cyc=%0d",
                   wr_addr, wr_data, wr_src, cyc, mon_e.addr, mon_e.data, mon_e.src, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic s, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.src = s; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {wr_en, wr_addr, wr_data, wr_src, key_fault, drop_count, locked, alu_ready, mem_ready}, 64'd0);
    rst = 1'b0;
    #1 chk("ready_after_reset", {alu_ready, mem_ready}, 2'b11);
  endtask

  // Offer one entry; lat_chk pins the write to the cycle after acceptance.
  task automatic push(input logic src, input logic [4:0] rd, input logic [31:0] d,
                      input bit exp_wr, input bit lat_chk);
    int waited = 0;
    @(negedge clk);
    if (src) begin mem_valid = 1'b1; mem_rd = rd; mem_data = d; end
    else     begin alu_valid = 1'b1; alu_rd = rd; alu_data = d; end
    forever begin
      #4;
      if (src ? mem_ready : alu_ready) begin
        if (exp_wr) expect_wr(rd, d, src, lat_chk ? cyc + 2 : -1);
        @(posedge clk);
        break;
      end
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        chk("push_timeout", 1, 0);
        break;
      end
    end
    #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic dual_stream(input int n);
    int ia = 0, im = 0, guard = 0;
    logic a_acc, m_acc;
    for (int k = 0; k < n; k++) begin
      expect_wr(5'(1 + k), 32'hA000_0000 + k, 1'b0, -1);
      expect_wr(5'(17 + k), 32'hB000_0000 + k, 1'b1, -1);
    end
    @(negedge clk);
    while ((ia < n || im < n) && guard < 100) begin
      alu_valid = (ia < n); alu_rd = 5'(1 + ia);  alu_data = 32'hA000_0000 + ia;
      mem_valid = (im < n); mem_rd = 5'(17 + im); mem_data = 32'hB000_0000 + im;
      #4;
      a_acc = alu_valid & alu_ready;
      m_acc = mem_valid & mem_ready;
      @(posedge clk);
      if (a_acc) ia++;
      if (m_acc) im++;
      @(negedge clk);
      guard++;
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    chk("dual_stream_accepted", {32'(ia), 32'(im)}, {32'(n), 32'(n)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    push(1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1);
    drain("single_alu_write");

    do_reset();
    dual_stream(4);
    drain("alternating_writes");

    push(1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rd0_drop_count", drop_count, 8'd0);
    push(1'b0, 5'd4, 32'h4444_0004, 1'b1, 1'b1);
    drain("write_after_rd0");

`ifdef WB_KEY_CHECK_EN
    do_reset();
    key_in = 16'h0031;
    key_access = 16'h0032;
    push(1'b0, 5'd3, 32'h3333_0003, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mismatch_state", {drop_count, key_fault, locked}, {8'd1, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7;
      #4 chk("locked_alu_ready", alu_ready, 1'b0);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    key_in = 16'h0032;
    @(negedge clk);
    chk("unlocked", locked, 1'b0);
    push(1'b0, 5'd7, 32'h0000_0007, 1'b1, 1'b1);
    push(1'b0, 5'd8, 32'h0000_0008, 1'b1, 1'b0);
    drain("writes_after_unlock");
    chk("fault_still_set", {drop_count, key_fault}, {8'd1, 1'b1});
    @(negedge clk) fault_clr = 1'b1;
    @(negedge clk) fault_clr = 1'b0;
    chk("fault_cleared", key_fault, 1'b0);
`else
    do_reset();
    key_in = 16'h0031;
    key_access = 16'h0032;
    push(1'b0, 5'd3, 32'h3333_0003, 1'b1, 1'b1);
    drain("keys_ignored_write");
    chk("keys_ignored_state", {drop_count, key_fault, locked}, 10'd0);
    key_in = 16'h0032;
`endif

    // Reset mid-flight with two entries parked in the ALU FIFO.
    do_reset();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h9999_0009;
    mem_valid = 1'b1; mem_rd = 5'd25; mem_data = 32'h2525_0025;
    expect_wr(5'd9, 32'h9999_0009, 1'b0, -1);
    @(negedge clk);
    alu_rd = 5'd10; alu_data = 32'h1010_0010;
    mem_rd = 5'd26; mem_data = 32'h2626_0026;
    @(negedge clk);
    alu_rd = 5'd11; alu_data = 32'h1111_0011;
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    alu_valid = 1'b0;
    @(negedge clk);
    chk("midflight_reset_outputs",
        {wr_en, wr_addr, wr_data, wr_src, key_fault, drop_count, locked, alu_ready, mem_ready}, 64'd0);
    chk("midflight_expected_done", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_write_after_reset", {wr_en, wr_addr, wr_data}, 38'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
